// File: rtl/snake_key_sched.sv
// snake_key_sched: PS/2 scancode handshake, make/break/E0 decode and direction queue for the snake game.
// Optional pause toggle on the space key when SNAKE_KEY_PAUSE_EN is defined.
module snake_key_sched #(
   parameter int QDEPTH      = 2,
   parameter int TIMEOUT_CYC = 1000000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       data_ready,
   input  logic [7:0] scancode,
   output logic       read,
   input  logic       game_tick,
   output logic [1:0] dir,
   output logic       dir_changed,
   output logic [2:0] q_count,
   output logic       overflow,
   output logic       pause
);
   localparam int CW = $clog2(TIMEOUT_CYC + 1);
   localparam logic [CW-1:0] TLIM = CW'(TIMEOUT_CYC - 1);
   localparam logic [2:0] QD = 3'(QDEPTH);

   typedef enum logic [1:0] {IDLE, ACK, WAIT_LOW} state_t;
   state_t state, state_nx;

   logic [7:0]    code;
   logic          ext, brk, tout;
   logic [CW-1:0] tcnt;
   logic [1:0]    q [0:3];
   logic          ack, is_e0, is_f0, make;
   logic          hit_up, hit_dn, hit_lf, hit_rt;
   logic          cmd, acc, full, pop, push, drop;
   logic [1:0]    cmd_dir, ref_dir, tidx, widx;

   assign ack     = state == ACK;
   assign is_e0   = code == 8'hE0;
   assign is_f0   = code == 8'hF0;
   assign make    = ack && !is_e0 && !is_f0 && !brk;
   assign hit_up  = ext ? code == 8'h75 : code == 8'h1D;
   assign hit_dn  = ext ? code == 8'h72 : code == 8'h1B;
   assign hit_lf  = ext ? code == 8'h6B : code == 8'h1C;
   assign hit_rt  = ext ? code == 8'h74 : code == 8'h23;
   assign cmd     = make && (hit_up || hit_dn || hit_lf || hit_rt);
   assign cmd_dir = hit_up ? 2'b10 : hit_dn ? 2'b11 : hit_lf ? 2'b01 : 2'b00;
   // Equal and reversed directions share bit1, so only a change of axis is accepted.
   assign tidx    = 2'(q_count - 3'd1);
   assign ref_dir = q_count != 3'd0 ? q[tidx] : dir;
   assign acc     = cmd && (cmd_dir[1] != ref_dir[1]);
   assign full    = q_count == QD;
   assign pop     = game_tick && q_count != 3'd0 && !pause;
   assign push    = acc && (!full || pop);
   assign drop    = acc && full && !pop;
   assign widx    = pop ? tidx : q_count[1:0];
   assign tout    = (ext || brk) && tcnt == TLIM;

   // Handshake state register and byte capture.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         code  <= '0;
      end else begin
         state <= state_nx;
         if (state == IDLE && data_ready) code <= scancode;
      end
   end

   // Handshake next state; read is the single ACK cycle.
   always_comb begin
      state_nx = state;
      read     = 1'b0;
      case (state)
         IDLE:     state_nx = data_ready ? ACK : IDLE;
         ACK: begin
            read     = 1'b1;
            state_nx = WAIT_LOW;
         end
         WAIT_LOW: state_nx = data_ready ? WAIT_LOW : IDLE;
         default:  state_nx = IDLE;
      endcase
   end

   // Prefix flags with a stale-prefix timeout.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ext  <= 1'b0;
         brk  <= 1'b0;
         tcnt <= '0;
      end else if (ack) begin
         ext  <= is_e0 || (is_f0 && ext);
         brk  <= is_f0 || (is_e0 && brk);
         tcnt <= '0;
      end else if (tout) begin
         ext  <= 1'b0;
         brk  <= 1'b0;
         tcnt <= '0;
      end else if (ext || brk) begin
         tcnt <= tcnt + 1'b1;
      end
   end

   // Direction queue: head at q[0], shifts on pop; push lands after the shift.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 4; i++) q[i] <= 2'b00;
         q_count     <= 3'd0;
         overflow    <= 1'b0;
         dir         <= 2'b00;
         dir_changed <= 1'b0;
      end else begin
         dir_changed <= pop;
         if (pop) dir <= q[0];
         if (pop) for (int i = 0; i < 3; i++) q[i] <= q[i+1];
         if (push) q[widx] <= cmd_dir;
         q_count <= q_count + 3'(push) - 3'(pop);
         if (drop) overflow <= 1'b1;
      end
   end

`ifdef SNAKE_KEY_PAUSE_EN
   // Space make toggles pause; its release goes through the brk path and is ignored.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) pause <= 1'b0;
      else if (make && !ext && code == 8'h29) pause <= !pause;
   end
`else
   assign pause = 1'b0;
`endif
endmodule

// File: doc/snake_key_sched.md
Name: snake_key_sched

Overview:
- Sits between the PS/2 keyboard receiver (scancode / data_ready / read handshake) and the snake game logic.
- Owns the receiver handshake and decodes make, break (F0) and extended (E0) prefix sequences into direction commands.
- Queues direction commands and releases one per game tick, rejecting 180-degree reversals and duplicates.

Parameters:
- QDEPTH, 2, direction queue depth in entries (1..4).
- TIMEOUT_CYC, 1000000, clk cycles after a prefix byte before pending prefix flags are discarded.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- data_ready  in  1  receiver has a byte; held high until read is seen
- scancode  in  8  byte from receiver, valid while data_ready=1
- read  out  1  one-cycle acknowledge to receiver
- game_tick  in  1  one-cycle pulse: snake advances one cell
- dir  out  2  current direction: 00 right, 01 left, 10 up, 11 down
- dir_changed  out  1  one-cycle pulse when dir is updated
- q_count  out  3  entries currently queued
- overflow  out  1  sticky: a valid command was dropped because the queue was full
- pause  out  1  pause state (see Optional Feature)

Behaviour:
- Reset values: read=0, dir=00, dir_changed=0, q_count=0, overflow=0, pause=0, ext=0, brk=0, FSM=IDLE, timeout counter=0.
- Handshake FSM:
  - IDLE: when data_ready=1, latch scancode and go to ACK.
  - ACK: read=1 for exactly this one cycle; decode the latched byte; go to WAIT_LOW.
  - WAIT_LOW: stay until data_ready=0, then go to IDLE. A byte is therefore never consumed twice.
- Decode, performed in the ACK cycle:
  - E0: set ext.
  - F0: set brk.
  - Any other byte with brk=1: release; clear ext and brk; no command.
  - Any other byte with brk=0: make; clear ext and brk; map to a direction.
    - ext=1: 75 up, 72 down, 6B left, 74 right.
    - ext=0: 1D up, 1B down, 1C left, 23 right.
    - Unmapped codes are ignored.
- Prefix timeout:
  - The counter runs while ext or brk is set and is cleared on every accepted byte.
  - When it reaches TIMEOUT_CYC-1, ext and brk clear.
- Queue acceptance for a decoded direction d:
  - Reference direction = last queued entry if q_count>0, else dir.
  - Reject if d equals the reference, or if d is the reverse of it (same bit1, different bit0).
  - Otherwise push if q_count<QDEPTH; if the queue is full, drop d and set overflow.
  - overflow clears only on rst.
- Pop:
  - On game_tick with q_count>0 (and not paused), dir <= head entry and dir_changed=1 on the next cycle.
  - On game_tick with an empty queue, nothing happens; dir holds.
- Simultaneous push and pop in the same cycle:
  - Both occur and q_count is unchanged.
  - The reference for the push is the tail before the pop.
  - A full queue with a simultaneous pop accepts the push with no overflow.
- Decode-to-queue latency: 1 cycle after ACK. Queue-to-dir latency: 1 cycle after game_tick.
- rst mid-handshake: FSM returns to IDLE and the queue empties. If data_ready is still high after rst releases, that byte is acknowledged again. This is accepted behaviour.

Optional Feature:
- Macro: SNAKE_KEY_PAUSE_EN.
- Defined:
  - A make of 29 (space, ext=0) toggles pause; its release is ignored.
  - While pause=1, game_tick does not pop and dir is frozen.
  - Direction commands are still queued normally.
- Undefined: pause is tied to 0 and scancode 29 is unmapped.

Test Plan:
- Reset, then 3 game_ticks with no keys -> dir=00, dir_changed never pulses, q_count=0.
- Bytes E0,75 each held until read, then game_tick -> read pulses once per byte (2 total); q_count=1, then dir=10 with a one-cycle dir_changed.
- From dir=00 send 1C (left), then tick -> rejected as reversal: q_count stays 0, dir=00. Then send 1D, 1C, tick, tick -> dir goes 10, then 01.
- QDEPTH=2, dir=00: send 1D, 1C, 1B with no ticks -> 1C accepted (up->left is legal) so q_count=2; 1B dropped, overflow=1.
- Send F0,1D -> release only, q_count=0. Send E0 and wait TIMEOUT_CYC cycles, then 75 -> non-extended 75 is unmapped, no command.
- With SNAKE_KEY_PAUSE_EN: send 29, then 1D, then tick -> pause=1, q_count=1, dir unchanged. Send 29, then tick -> pause=0, dir=10.
